alu_flag_stage: RTL and testbench

Registered result/flag stage that sits directly downstream of the 8-bit ripple-carry adder. It captures the adder's sum and carry-out together with the operands that produced them, and derives the Z/N/C/V status flags. Results are held in a small in-order FIFO with a valid/ready handshake toward the consumer, which is the register-file writeback or the branch unit.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_flag_calc.sv | 30 +++
 rtl/alu_flag_stage.sv | 126 ++++++++++++
 tb/tb_alu_flag_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result/flag stage: flag bit positions
// inside the 4-bit flag vector and the packed FIFO entry layout.
package alu_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [7:0] result;
        logic [3:0] flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational Z/N/C/V derivation from the adder operands and outputs.
// C is the raw adder carry-out; for subtract C=1 means no borrow.
module alu_flag_calc
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    input  logic [7:0] sum,
    input  logic       cout,
    output logic [3:0] flags
);

    logic [7:0] b_eff;
    logic       unused_low;

    assign b_eff      = sub ? ~b : b;
    // Only the sign bits feed the overflow test.
    assign unused_low = ^{a[6:0], b_eff[6:0]};

    // Flag vector {V,C,N,Z}.
    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (sum == 8'h00);
        flags[FLAG_N] = sum[7];
        flags[FLAG_C] = cout;
        flags[FLAG_V] = (a[7] == b_eff[7]) && (sum[7] != a[7]);
    end

endmodule

// File: rtl/alu_flag_stage.sv
// Registered result/flag stage behind the 8-bit adder: in-order FIFO of
// {sum, flags} with valid/ready on both sides.
// Optional feature macro: ALU_STICKY_V_EN adds sticky_v / sticky_clr.
module alu_flag_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       in_sub,
    input  logic [7:0] in_sum,
    input  logic       in_cout,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
`ifdef ALU_STICKY_V_EN
    output logic [3:0] out_flags,
    output logic       sticky_v,
    input  logic       sticky_clr
`else
    output logic [3:0] out_flags
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    alu_entry_t      mem [DEPTH];
    alu_entry_t      in_entry;
    alu_entry_t      head_q;
    alu_entry_t      head_n;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_n;
    logic [AW:0]     count;
    logic [AW:0]     count_n;
    logic [3:0]      in_flags;
    logic            push;
    logic            pop;

    alu_flag_calc u_flag_calc (
        .a     (in_a),
        .b     (in_b),
        .sub   (in_sub),
        .sum   (in_sum),
        .cout  (in_cout),
        .flags (in_flags)
    );

    assign in_entry   = '{result: in_sum, flags: in_flags};
    assign in_ready   = (count < FULL_CNT);
    assign out_valid  = (count != '0);
    assign push       = in_valid && in_ready && !flush;
    assign pop        = out_valid && out_ready && !flush;
    assign out_result = head_q.result;
    assign out_flags  = head_q.flags;

    // Next occupancy / read pointer, and the entry that will sit at the head.
    // A push landing in the slot that becomes the head is forwarded so the
    // registered head never shows a stale slot; an empty FIFO holds the head.
    always_comb begin
        count_n  = count;
        rd_ptr_n = rd_ptr;
        if (flush) begin
            count_n  = '0;
            rd_ptr_n = '0;
        end else begin
            if (push && !pop)
                count_n = count + (AW+1)'(1);
            else if (pop && !push)
                count_n = count - (AW+1)'(1);
            if (pop)
                rd_ptr_n = rd_ptr + AW'(1);
        end
        head_n = head_q;
        if (count_n != '0)
            head_n = (push && (wr_ptr == rd_ptr_n)) ? in_entry : mem[rd_ptr_n];
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head_q <= '0;
        end else begin
            if (flush)
                wr_ptr <= '0;
            else if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            head_q <= head_n;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

`ifdef ALU_STICKY_V_EN
    // Accumulated overflow; a V=1 push beats a simultaneous clear, flush ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_v <= 1'b0;
        else if (push && in_flags[FLAG_V])
            sticky_v <= 1'b1;
        else if (sticky_clr)
            sticky_v <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_alu_flag_stage.sv
// Self-checking bench for alu_flag_stage: directed cases plus randomized
// traffic checked against a queue-based reference model.
module tb_alu_flag_stage;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_sub;
    logic [7:0] in_sum;
    logic       in_cout;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_flags;
`ifdef ALU_STICKY_V_EN
    logic       sticky_v;
    logic       sticky_clr;
`endif

    int         tests = 0;
    int         fails = 0;
    logic [11:0] q[$];
    bit         m_sticky = 1'b0;

    always #5 clk = ~clk;

    alu_flag_stage #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .in_sum     (in_sum),
        .in_cout    (in_cout),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
`ifdef ALU_STICKY_V_EN
        .out_flags  (out_flags),
        .sticky_v   (sticky_v),
        .sticky_clr (sticky_clr)
`else
        .out_flags  (out_flags)
`endif
    );

    // Count a comparison and report any mismatch.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference flags from signed/unsigned arithmetic rather than bit rules.
    function automatic logic [3:0] ref_flags(input logic [7:0] a, input logic [7:0] b,
                                             input bit s, input logic [7:0] sum, input bit co);
        int sa, sb, r;
        logic [3:0] f;
        sa = $signed(a);
        sb = $signed(b);
        r  = s ? (sa - sb) : (sa + sb);
        f[0] = (sum == 8'h00);
        f[1] = (sum >= 8'h80);
        f[2] = co;
        f[3] = (r > 127) || (r < -128);
        return f;
    endfunction

    task automatic check_outputs();
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
        if (q.size() != 0) begin
            chk("out_result", {24'd0, out_result}, {24'd0, q[0][11:4]});
            chk("out_flags", {28'd0, out_flags}, {28'd0, q[0][3:0]});
        end
`ifdef ALU_STICKY_V_EN
        chk("sticky_v", {31'd0, sticky_v}, {31'd0, m_sticky});
`endif
    endtask

    // One clock of traffic: drive, advance the model, check after the edge.
    task automatic step(input bit v, input logic [7:0] a, input logic [7:0] b, input bit s,
                        input logic [7:0] sum, input bit co, input bit ordy, input bit fl,
                        input bit sclr);
        bit m_push, m_pop;
        logic [11:0] e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_sub    = s;
        in_sum    = sum;
        in_cout   = co;
        out_ready = ordy;
        flush     = fl;
`ifdef ALU_STICKY_V_EN
        sticky_clr = sclr;
`endif
        e      = {sum, ref_flags(a, b, s, sum, co)};
        m_push = v && (q.size() < DEPTH) && !fl;
        m_pop  = (q.size() != 0) && ordy && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (m_pop)
                void'(q.pop_front());
            if (m_push)
                q.push_back(e);
        end
        if (m_push && e[3])
            m_sticky = 1'b1;
        else if (sclr)
            m_sticky = 1'b0;
        check_outputs();
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    // Random push whose sum/carry come from the true add/subtract result.
    task automatic rand_step(input bit v, input bit ordy, input bit fl, input bit sclr);
        logic [7:0] a, b, sum;
        bit s, co;
        int t;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        s = 1'($urandom_range(0, 1));
        if (s) begin
            t  = int'(a) - int'(b);
            co = (a >= b);
        end else begin
            t  = int'(a) + int'(b);
            co = (t > 255);
        end
        sum = 8'(t);
        step(v, a, b, s, sum, co, ordy, fl, sclr);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_sum    = '0;
        in_cout   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
`ifdef ALU_STICKY_V_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst out_result", {24'd0, out_result}, 32'h00);
        chk("rst out_flags", {28'd0, out_flags}, 32'h0);
`ifdef ALU_STICKY_V_EN
        chk("rst sticky_v", {31'd0, sticky_v}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Test-plan flag cases.
        step(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1 valid", {31'd0, out_valid}, 32'd1);
        chk("t1 result", {24'd0, out_result}, 32'h80);
        chk("t1 flags", {28'd0, out_flags}, 32'hA);
        idle(1'b1);
        step(1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2 flags", {28'd0, out_flags}, 32'h5);
        idle(1'b1);
        step(1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3 flags", {28'd0, out_flags}, 32'hC);
        idle(1'b1);

        // Backpressure: third push held until a slot frees.
        step(1'b1, 8'h01, 8'h10, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 8'h20, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp in_ready low", {31'd0, in_ready}, 32'd0);
        step(1'b1, 8'h03, 8'h30, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp head 11", {24'd0, out_result}, 32'h11);
        step(1'b1, 8'h03, 8'h30, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp head 22", {24'd0, out_result}, 32'h22);
        chk("bp in_ready back", {31'd0, in_ready}, 32'd1);
        step(1'b1, 8'h03, 8'h30, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp head 33", {24'd0, out_result}, 32'h33);
        idle(1'b1);
        chk("bp drained", {31'd0, out_valid}, 32'd0);

        // Flush with a coincident push while one entry is stored.
        step(1'b1, 8'h05, 8'h05, 1'b0, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h06, 8'h06, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        idle(1'b0);

`ifdef ALU_STICKY_V_EN
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("sticky set", {31'd0, sticky_v}, 32'd1);
        step(1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sticky after flush", {31'd0, sticky_v}, 32'd1);
        step(1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("sticky set wins", {31'd0, sticky_v}, 32'd1);
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("sticky cleared", {31'd0, sticky_v}, 32'd0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                      $urandom_range(0, 24) == 0, $urandom_range(0, 15) == 0);

        // Reset asserted mid-drain.
        step(1'b1, 8'h10, 8'h01, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h20, 8'h02, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        q.delete();
        m_sticky = 1'b0;
        chk("rst mid out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst mid in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst mid out_result", {24'd0, out_result}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1);
        chk("post rst out_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
